// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronises the board reset, holds all domains in reset, then releases
// the reset channels in staggered index order. Also handles software and watchdog resets.
module rst_sequencer #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGGER     = 4,
  parameter int unsigned WDT_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              sw_rst_req,
  input  logic              wdt_en,
  input  logic              wdt_kick,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              ready,
  output logic [1:0]        rst_cause
);

  localparam int unsigned RelLast = (NUM_CH - 1) * STAGGER;
  localparam int unsigned CntMax  = (HOLD_CYCLES > RelLast + 1) ? HOLD_CYCLES : RelLast + 1;
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned WdtW    = $clog2(WDT_CYCLES);

  localparam logic [1:0] CausePor = 2'd0;
  localparam logic [1:0] CauseSw  = 2'd1;
  localparam logic [1:0] CauseWdt = 2'd2;

  typedef enum logic [1:0] {
    StReset,
    StHold,
    StRelease,
    StRun
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q;
  logic [WdtW-1:0]        wdt_cnt_q;
  logic                   rst_sync;
  logic                   wdt_run;
  logic                   wdt_timeout;
  logic                   int_req;

  // Assertion of rst_in is async; release ripples through the stages.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync    = sync_q[SYNC_STAGES-1];
  assign wdt_run     = (state_q == StRun) && wdt_en;
  assign wdt_timeout = wdt_run && !wdt_kick && (wdt_cnt_q == WdtW'(WDT_CYCLES - 1));
  // Internal requests are ignored until the synchronised release has been seen.
  assign int_req     = (state_q != StReset) && (sw_rst_req || wdt_timeout);

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= StReset;
      cnt_q     <= '0;
      wdt_cnt_q <= '0;
      rst_n_out <= '0;
      ready     <= 1'b0;
      rst_cause <= CausePor;
    end else if (int_req) begin
      state_q   <= StHold;
      cnt_q     <= '0;
      wdt_cnt_q <= '0;
      rst_n_out <= '0;
      ready     <= 1'b0;
      rst_cause <= sw_rst_req ? CauseSw : CauseWdt;
    end else begin
      // Kick has priority over the increment; outside RUN or when disabled it idles at zero.
      if (wdt_run && !wdt_kick) begin
        wdt_cnt_q <= wdt_cnt_q + WdtW'(1);
      end else begin
        wdt_cnt_q <= '0;
      end

      case (state_q)
        StReset: begin
          if (rst_sync) begin
            state_q <= StHold;
            cnt_q   <= '0;
          end
        end
        StHold: begin
          if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
            state_q <= StRelease;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRelease: begin
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (cnt_q == CntW'(k * STAGGER)) begin
              rst_n_out[k] <= 1'b1;
            end
          end
          if (cnt_q == CntW'(RelLast)) begin
            state_q <= StRun;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRun: begin
          ready <= 1'b1;
        end
        default: begin
          state_q <= StReset;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: timed expectations are queued against absolute edge numbers and
// checked by a monitor just after each rising edge.
module tb_rst_sequencer;

  localparam int unsigned NumCh   = 4;
  localparam int unsigned Sync    = 2;
  localparam int unsigned Hold    = 16;
  localparam int unsigned Stagger = 4;
  localparam int unsigned Wdt     = 64;

  logic             clk = 1'b0;
  logic             rst_in = 1'b0;
  logic             sw_rst_req = 1'b0;
  logic             wdt_en = 1'b0;
  logic             wdt_kick = 1'b0;
  logic [NumCh-1:0] rst_n_out;
  logic             ready;
  logic [1:0]       rst_cause;

  rst_sequencer #(
    .NUM_CH     (NumCh),
    .SYNC_STAGES(Sync),
    .HOLD_CYCLES(Hold),
    .STAGGER    (Stagger),
    .WDT_CYCLES (Wdt)
  ) dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .sw_rst_req(sw_rst_req),
    .wdt_en    (wdt_en),
    .wdt_kick  (wdt_kick),
    .rst_n_out (rst_n_out),
    .ready     (ready),
    .rst_cause (rst_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [3:0] rst;
    logic       rdy;
    logic [1:0] cause;
    string      name;
  } exp_t;

  typedef struct {
    int         e;
    logic [3:0] rst;
    logic       rdy;
  } po_t;

  exp_t sb[$];
  po_t  po_tab[11];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic void check(string name, logic [6:0] act, logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rst_n_out=%b ready=%b cause=%0d, want rst_n_out=%b ready=%b cause=%0d",
               name, act[6:3], act[2], act[1:0], exp[6:3], exp[2], exp[1:0]);
    end
  endfunction

  // Monitor: compare every queued expectation that falls due on this edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].edge_no <= cyc) begin
          check(sb[i].name, {rst_n_out, ready, rst_cause},
                {sb[i].rst, sb[i].rdy, sb[i].cause});
          sb.delete(i);
        end
      end
    end
  end

  task automatic push(int e, logic [3:0] r, logic rd, logic [1:0] c, string nm);
    exp_t x;
    x.edge_no = e;
    x.rst     = r;
    x.rdy     = rd;
    x.cause   = c;
    x.name    = nm;
    sb.push_back(x);
  endtask

  // Expected release timeline for an internal sequence whose HOLD entry edge is t.
  task automatic push_seq(int t, logic [1:0] c, string nm);
    int rel;
    push(t, 4'h0, 1'b0, c, {nm, " start"});
    push(t + Hold, 4'h0, 1'b0, c, {nm, " hold end"});
    for (int k = 0; k < NumCh; k++) begin
      rel = t + Hold + 1 + k * Stagger;
      push(rel - 1, 4'((1 << k) - 1), 1'b0, c, $sformatf("%s pre ch%0d", nm, k));
      push(rel, 4'((1 << (k + 1)) - 1), 1'b0, c, $sformatf("%s ch%0d", nm, k));
    end
    push(t + Hold + 2 + (NumCh - 1) * Stagger, 4'hf, 1'b1, c, {nm, " ready"});
  endtask

  function automatic int ready_edge(int t);
    return t + Hold + 2 + (NumCh - 1) * Stagger;
  endfunction

  task automatic goto(int n);
    while (cyc < n) @(negedge clk);
  endtask

  // sw_rst_req is sampled at edge s.
  task automatic pulse_sw(int s);
    goto(s - 1);
    sw_rst_req = 1'b1;
    goto(s);
    sw_rst_req = 1'b0;
  endtask

  // Called at a negedge with rst_in low; includes an ignored sw request in RESET at E2.
  task automatic power_on(string nm);
    int r;
    r = cyc;
    rst_in = 1'b1;
    foreach (po_tab[i]) begin
      push(r + po_tab[i].e, po_tab[i].rst, po_tab[i].rdy, 2'd0,
           $sformatf("%s E%0d", nm, po_tab[i].e));
    end
    pulse_sw(r + 2);
    goto(r + 40);
  endtask

  initial begin
    int s;
    int s3;
    int c;
    int t;
    int run1;
    int k0;

    po_tab = '{'{1, 4'h0, 1'b0}, '{19, 4'h0, 1'b0}, '{20, 4'h1, 1'b0}, '{23, 4'h1, 1'b0},
               '{24, 4'h3, 1'b0}, '{27, 4'h3, 1'b0}, '{28, 4'h7, 1'b0}, '{31, 4'h7, 1'b0},
               '{32, 4'hf, 1'b0}, '{33, 4'hf, 1'b1}, '{40, 4'hf, 1'b1}};

    #1;
    check("por async", {rst_n_out, ready, rst_cause}, 7'b0);
    goto(5);
    power_on("por");

    s = cyc + 3;
    push(s + 1, 4'h0, 1'b0, 2'd1, "sw s+1");
    push_seq(s, 2'd1, "sw");
    pulse_sw(s);
    goto(ready_edge(s) + 2);

    // Request in RELEASE after ch0/ch1 are out: restart from HOLD.
    s  = cyc + 2;
    s3 = s + Hold + 1 + Stagger + 2;
    push(s, 4'h0, 1'b0, 2'd1, "rel start");
    push(s + Hold + 1, 4'h1, 1'b0, 2'd1, "rel ch0");
    push(s3 - 1, 4'h3, 1'b0, 2'd1, "rel mid");
    push_seq(s3, 2'd1, "rel restart");
    pulse_sw(s);
    pulse_sw(s3);
    goto(ready_edge(s3) + 2);

    c = cyc;
    push(c + Wdt + 10, 4'hf, 1'b1, 2'd1, "wdt off");
    goto(c + Wdt + 12);

    wdt_en = 1'b1;
    c = cyc;
    t = c + Wdt;
    push(t - 1, 4'hf, 1'b1, 2'd1, "wdt pre");
    push_seq(t, 2'd2, "wdt");
    run1 = ready_edge(t) - 1;

    push(run1 + 64, 4'hf, 1'b1, 2'd2, "kick 64");
    push(run1 + 120, 4'hf, 1'b1, 2'd2, "kick 120");
    push(run1 + 199, 4'hf, 1'b1, 2'd2, "kick 199");
    for (int k = 1; k <= 4; k++) begin
      goto(run1 + 50 * k - 1);
      wdt_kick = 1'b1;
      goto(run1 + 50 * k);
      wdt_kick = 1'b0;
    end

    // Software request on the same edge as the timeout: software wins.
    k0 = run1 + 200;
    push(k0 + Wdt - 1, 4'hf, 1'b1, 2'd2, "coinc pre");
    push_seq(k0 + Wdt, 2'd1, "coinc");
    pulse_sw(k0 + Wdt);
    wdt_en = 1'b0;
    goto(ready_edge(k0 + Wdt) + 2);

    @(posedge clk);
    #2;
    rst_in = 1'b0;
    #1;
    check("async drop", {rst_n_out, ready, rst_cause}, 7'b0);
    goto(cyc + 3);
    power_on("por2");

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d pending, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
